boot_loader_ctrl: RTL and testbench

- Sequences the serial-byte-to-word path used at boot. Consumes a byte stream from the receive side and parses a length header.
- Assembles payload bytes into big-endian words, with the first byte received landing in the MSB.
- Writes each word to instruction memory through a ready handshake, then checks an 8-bit additive checksum trailer.
- Sits between the UART receiver and the instruction-memory write port. Reports done or error to the core-reset logic.

---
 rtl/boot_loader_ctrl.sv | 158 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// Boot loader: parses a length header from a byte stream, packs payload bytes
// big-endian into words, writes them to instruction memory, then verifies an 8-bit additive trailer.
module boot_loader_ctrl #(
  parameter int DATAW_IN  = 8,
  parameter int DATAW_OUT = 32,
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rx_valid,
  input  logic [DATAW_IN-1:0]  rx_data,
  output logic                 rx_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATAW_OUT-1:0] mem_wdata,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [ADDR_W:0]      words_written
);

  localparam int BPW       = DATAW_OUT / DATAW_IN;
  localparam int HDR_BYTES = 4;
  localparam int HDR_W     = HDR_BYTES * DATAW_IN;
  localparam int MAXB      = (BPW > HDR_BYTES) ? BPW : HDR_BYTES;
  localparam int IDX_W     = $clog2(MAXB);

  localparam logic [IDX_W-1:0] HDR_LAST  = IDX_W'(HDR_BYTES - 1);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(BPW - 1);
  localparam logic [HDR_W:0]   LEN_MAX   = (HDR_W+1)'(1) << ADDR_W;

  localparam logic [1:0] EC_NONE = 2'd0;
  localparam logic [1:0] EC_OVF  = 2'd1;
  localparam logic [1:0] EC_CSUM = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAY, S_WR, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t state, state_n;

  logic [HDR_W-DATAW_IN-1:0] hdr_sh;
  logic [IDX_W-1:0]          byte_idx;
  logic [ADDR_W:0]           len_q;
  logic [DATAW_IN-1:0]       acc;

  logic              byte_xfer, wr_xfer, hdr_last, word_last;
  logic              len_zero, len_ovf, restart;
  logic [HDR_W-1:0]  n_full;
  logic [ADDR_W:0]   ww_inc;

  always_comb begin
    rx_ready = (state == S_HDR) || (state == S_PAY) || (state == S_CSUM);
    mem_we   = (state == S_WR);
    busy     = rx_ready || mem_we;
  end

  assign byte_xfer = rx_valid && rx_ready;
  assign wr_xfer   = mem_we && mem_ready;
  assign hdr_last  = (byte_idx == HDR_LAST);
  assign word_last = (byte_idx == WORD_LAST);
  assign n_full    = {hdr_sh, rx_data};
  assign len_zero  = (n_full == '0);
  assign len_ovf   = ({1'b0, n_full} > LEN_MAX);
  assign ww_inc    = words_written + (ADDR_W+1)'(1);
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_n = S_HDR;
      S_HDR: begin
        if (byte_xfer && hdr_last) begin
          if (len_zero)     state_n = S_CSUM;
          else if (len_ovf) state_n = S_ERR;
          else              state_n = S_PAY;
        end
      end
      S_PAY:  if (byte_xfer && word_last) state_n = S_WR;
      S_WR:   if (wr_xfer) state_n = (ww_inc == len_q) ? S_CSUM : S_PAY;
      S_CSUM: if (byte_xfer) state_n = (rx_data == acc) ? S_DONE : S_ERR;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_sh        <= '0;
      byte_idx      <= '0;
      len_q         <= '0;
      acc           <= '0;
      mem_wdata     <= '0;
      mem_addr      <= '0;
      words_written <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= EC_NONE;
    end else if (restart) begin
      hdr_sh        <= '0;
      byte_idx      <= '0;
      len_q         <= '0;
      acc           <= '0;
      mem_wdata     <= '0;
      mem_addr      <= ADDR_W'(BASE_ADDR);
      words_written <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= EC_NONE;
    end else begin
      case (state)
        S_HDR: if (byte_xfer) begin
          hdr_sh   <= n_full[HDR_W-DATAW_IN-1:0];
          byte_idx <= hdr_last ? '0 : byte_idx + IDX_W'(1);
          if (hdr_last) begin
            len_q <= n_full[ADDR_W:0];
            if (!len_zero && len_ovf) begin
              err      <= 1'b1;
              err_code <= EC_OVF;
            end
          end
        end
        S_PAY: if (byte_xfer) begin
          // first byte of a word ends up in the MSB after BPW shifts
          mem_wdata <= (mem_wdata << DATAW_IN) | DATAW_OUT'(rx_data);
          acc       <= acc + rx_data;
          byte_idx  <= word_last ? '0 : byte_idx + IDX_W'(1);
        end
        S_WR: if (wr_xfer) begin
          words_written <= ww_inc;
          mem_addr      <= mem_addr + ADDR_W'(1);
        end
        S_CSUM: if (byte_xfer) begin
          if (rx_data == acc) begin
            done <= 1'b1;
          end else begin
            err      <= 1'b1;
            err_code <= EC_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  a_wr_stable: assert property (@(posedge clk) disable iff (!rst)
    (mem_we && !mem_ready) |=> (mem_we && $stable(mem_addr) && $stable(mem_wdata)));
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst) !(mem_we && rx_ready));

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: nominal, backpressure, zero length,
// overflow, bad checksum with restart, and reset mid-payload.
module tb_boot_loader_ctrl;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              mem_ready = 1'b1;
  logic              rx_ready, mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_written;

  boot_loader_ctrl #(.DATAW_IN(8), .DATAW_OUT(32), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int we_cycles = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  always @(posedge clk) begin
    if (rst && mem_we) begin
      we_cycles++;
      if (mem_ready) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
      end
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    we_cycles = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_vec++; n_bad++;
      $display("FAIL byte_timeout byte=%h rx_ready=0 required 1", b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_nominal_writes(input string tag);
    n_vec++;
    if (wa.size() !== 2) begin
      n_bad++; $display("FAIL %s_write_count got %0d required 2", tag, wa.size());
    end else begin
      n_vec++;
      if (wa[0] !== 14'd0 || wd[0] !== 32'hDEADBEEF) begin
        n_bad++; $display("FAIL %s_write0 got (%0d,%h) required (0,deadbeef)", tag, wa[0], wd[0]);
      end
      n_vec++;
      if (wa[1] !== 14'd1 || wd[1] !== 32'h01020304) begin
        n_bad++; $display("FAIL %s_write1 got (%0d,%h) required (1,01020304)", tag, wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({rx_ready, mem_we, busy, done, err} !== 5'b0 || err_code !== 2'd0 ||
        mem_addr !== '0 || mem_wdata !== '0 || words_written !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b we=%b busy=%b done=%b err=%b ec=%0d addr=%0d wd=%h ww=%0d required all 0",
               rx_ready, mem_we, busy, done, err, err_code, mem_addr, mem_wdata, words_written);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h42};
    clear_log();
    do_start();
    n_vec++;
    if (busy !== 1'b1 || rx_ready !== 1'b1) begin
      n_bad++; $display("FAIL nom_busy got busy=%b rdy=%b required 1 1", busy, rx_ready);
    end
    send_stream(s, 1'b0);
    check_nominal_writes("nom");
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0 || words_written !== 15'd2 || busy !== 1'b0) begin
      n_bad++; $display("FAIL nom_result got done=%b err=%b ww=%0d busy=%b required 1 0 2 0",
                        done, err, words_written, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s[$];
    logic [ADDR_W-1:0] a0;
    logic [31:0] d0;
    int t;
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h42};
    clear_log();
    mem_ready = 1'b0;
    do_start();
    fork
      send_stream(s, 1'b1);
      begin
        t = 0;
        while (!mem_we && t < 300) begin
          @(negedge clk);
          t++;
        end
        n_vec++;
        if (mem_we !== 1'b1) begin
          n_bad++; $display("FAIL bp_we_timeout got mem_we=%b required 1", mem_we);
        end
        a0 = mem_addr;
        d0 = mem_wdata;
        n_vec++;
        if (a0 !== 14'd0 || d0 !== 32'hDEADBEEF) begin
          n_bad++; $display("FAIL bp_first_req got (%0d,%h) required (0,deadbeef)", a0, d0);
        end
        repeat (3) begin
          @(negedge clk);
          n_vec++;
          if (mem_we !== 1'b1 || rx_ready !== 1'b0 || mem_addr !== a0 || mem_wdata !== d0) begin
            n_bad++; $display("FAIL bp_stall got we=%b rdy=%b addr=%0d wd=%h required 1 0 %0d %h",
                              mem_we, rx_ready, mem_addr, mem_wdata, a0, d0);
          end
        end
        mem_ready = 1'b1;
      end
    join
    check_nominal_writes("bp");
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0 || words_written !== 15'd2) begin
      n_bad++; $display("FAIL bp_result got done=%b err=%b ww=%0d required 1 0 2", done, err, words_written);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    do_start();
    send_stream(s, 1'b0);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0 || we_cycles !== 0) begin
      n_bad++; $display("FAIL zero_ok got done=%b err=%b we_cycles=%0d required 1 0 0", done, err, we_cycles);
    end
    s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    clear_log();
    do_start();
    send_stream(s, 1'b0);
    n_vec++;
    if (err !== 1'b1 || err_code !== 2'd2 || done !== 1'b0 || we_cycles !== 0) begin
      n_bad++; $display("FAIL zero_bad got err=%b ec=%0d done=%b we_cycles=%0d required 1 2 0 0",
                        err, err_code, done, we_cycles);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h40, 8'h01};
    clear_log();
    do_start();
    send_stream(s, 1'b0);
    n_vec++;
    if (err !== 1'b1 || err_code !== 2'd1 || done !== 1'b0) begin
      n_bad++; $display("FAIL ovf_err got err=%b ec=%0d done=%b required 1 1 0", err, err_code, done);
    end
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (rx_ready !== 1'b0 || we_cycles !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ovf_after got rdy=%b we_cycles=%0d busy=%b required 0 0 0", rx_ready, we_cycles, busy);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_bad_csum();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h43};
    clear_log();
    do_start();
    send_stream(s, 1'b0);
    check_nominal_writes("bad");
    n_vec++;
    if (err !== 1'b1 || err_code !== 2'd2 || done !== 1'b0) begin
      n_bad++; $display("FAIL bad_err got err=%b ec=%0d done=%b required 1 2 0", err, err_code, done);
    end
    s[12] = 8'h42;
    clear_log();
    do_start();
    n_vec++;
    if (err !== 1'b0 || err_code !== 2'd0 || words_written !== '0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL restart_clear got err=%b ec=%0d ww=%0d busy=%b required 0 0 0 1",
                        err, err_code, words_written, busy);
    end
    send_stream(s, 1'b0);
    check_nominal_writes("rst_ok");
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL restart_done got done=%b err=%b required 1 0", done, err);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD};
    clear_log();
    do_start();
    send_stream(s, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({rx_ready, mem_we, busy, done, err} !== 5'b0 || err_code !== 2'd0 ||
        mem_addr !== '0 || mem_wdata !== '0 || words_written !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs got rdy=%b we=%b busy=%b done=%b err=%b ec=%0d addr=%0d wd=%h ww=%0d required all 0",
               rx_ready, mem_we, busy, done, err, err_code, mem_addr, mem_wdata, words_written);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h42};
    clear_log();
    do_start();
    send_stream(s, 1'b0);
    check_nominal_writes("midrst");
    n_vec++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL midrst_done got %b required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_zero_len();
    test_overflow();
    test_bad_csum();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
